io_arbiter: RTL and testbench
=============================

IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'hFFFF_0000, base of the 16-byte peripheral window; bits [3:0] are ignored.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports mN_req  input  1  access request, for N = 0 (CPU) and N = 1 (boot loader).
REQ-005 SHALL have ports mN_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports mN_size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-007 SHALL have ports mN_addr  input  32  byte address.
REQ-008 SHALL have ports mN_wdata  input  32  store data.
REQ-009 SHALL have ports mN_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports mN_err  output  1  valid with ack: address outside the window.
REQ-011 SHALL have ports mN_rdata  output  32  load data, valid with ack.
REQ-012 SHALL have port per_state  output  3  3'd6 while accessing the peripheral, else 3'd0.
REQ-013 SHALL have port per_en  output  1  peripheral enable.
REQ-014 SHALL have ports per_load and per_store  output  1 each  access type.
REQ-015 SHALL have port per_size  output  2  latched mN_size.
REQ-016 SHALL have port per_addr  output  32  latched address.
REQ-017 SHALL have port per_wdata  output  32  latched store data.
REQ-018 SHALL have port per_rdata  input  32  peripheral read data; the peripheral registers it one cycle after its access cycle.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE, plus IDLE -> ERR -> IDLE.
REQ-020 SHALL, in IDLE with any req high, select a requester and latch its we/size/addr/wdata on that edge.
- In-window (addr[31:4] == IO_BASE[31:4]): next state ACCESS.
- Out-of-window: next state ERR.
REQ-021 SHALL arbitrate round-robin: with both requests high, grant the requester not granted last; after reset, m0 wins.
REQ-022 SHALL, in ACCESS (exactly one cycle), drive per_state = 3'd6, per_en = 1, and exactly one of per_load/per_store.
REQ-023 SHALL, in WAIT, drive per_en = per_load = per_store = 0 and register per_rdata into the rdata buffer at the end of the cycle.
REQ-024 SHALL, in RESP, pulse the granted mN_ack for one cycle with mN_err = 0.
- mN_rdata = captured data for loads; 0 for stores.
REQ-025 SHALL, in ERR, pulse the granted mN_ack for one cycle with mN_err = 1 and mN_rdata = 0, without asserting per_en.
REQ-026 SHALL meet this latency, with the request sampled in IDLE at cycle T:
- in-window: ack at T+3, next grant no earlier than T+4;
- out-of-window: ack at T+1, next grant at T+2.
REQ-027 SHALL never assert the ack of the non-granted requester; that requester's req stays pending.
REQ-028 SHALL complete an accepted transaction and pulse its ack even if its req drops before completion.
REQ-029 SHALL NOT re-sample mN_* after acceptance; changes to them mid-transaction have no effect.
REQ-030 SHALL drive all mN_* outputs and per_en/per_load/per_store/per_state from registers or decoded state only, with no combinational path from mN_req.
REQ-031 SHALL hold per_addr/per_wdata/per_size stable from ACCESS through RESP.

Reset
REQ-032 SHALL, on rst high at a rising edge, from any state:
- go to IDLE;
- set round-robin pointer to favour m0;
- clear all ack/err, per_en/per_load/per_store;
- set per_state = 0, rdata buffer = 0, per_addr/per_wdata/per_size = 0.
REQ-033 SHALL drop any in-flight transaction on reset mid-operation without issuing an ack; the requester re-issues it.

Structure
REQ-034 SHALL take the FSM state encoding, PER_ACCESS_STATE = 3'd6, and the size codes (BYTE, HALF, WORD) from a shared package io_pkg.
REQ-035 SHALL place the two-input round-robin grant logic and its pointer in sub-module rr_arb2; the FSM and datapath latches stay in io_arbiter.

Verification
REQ-036 SHALL cover: m0 loads addr 0xFFFF_0004 with per_rdata = 0x0000_0041 -> per_en at T+1 with per_load = 1, per_state = 6; m0_ack at T+3 with rdata 0x41, err 0.
REQ-037 SHALL cover: m1 stores 1 to 0xFFFF_0002 -> per_store = 1, per_addr = 0xFFFF_0002, per_wdata = 1 for exactly one cycle; m1_ack at T+3, rdata 0.
REQ-038 SHALL cover: m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1; one ack every 4 cycles; no simultaneous acks.
REQ-039 SHALL cover: m0 loads 0x0000_1000 -> m0_ack at T+1 with err = 1, rdata 0; per_en never asserted.
REQ-040 SHALL cover: rst asserted during WAIT -> next cycle IDLE; no ack; per_en = 0; the next simultaneous request is granted to m0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the peripheral IO arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package io_pkg;

    // Arbiter FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } io_state_t;

    // per_state value presented to the peripheral during its access cycle
    localparam logic [2:0] PER_ACCESS_STATE = 3'd6;

    // Access size codes carried on mN_size / per_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } io_size_t;

    // True when addr falls inside the 16-byte window starting at base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with its last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the accepting edge.
// Backpressure: pointer only moves when the caller asserts take.
//
// Ports: clk, rst (sync, active-high); req0/req1 requests; take = the
// current grant is being accepted this cycle; gnt = index of the winner
// (0/1); any = at least one request is high.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt,
    output logic any
);

    // Index of the requester granted most recently. Resetting it to 1 makes
    // m0 win the first contended arbitration.
    logic last_q;

    assign any = req0 | req1;

    always_comb begin
        gnt = req1;
        if (req0 && req1) begin
            gnt = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take && any) begin
            last_q <= gnt;
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// Arbitrates a CPU (m0) and boot loader (m1) onto one 16-byte peripheral window.
// Latency: in-window ack 3 cycles after acceptance, out-of-window ack after 1.
// Backpressure: a losing or late requester simply holds req until it is granted.
//
// Ports: clk, rst (sync, active-high); mN_req/we/size/addr/wdata request
// side and mN_ack/err/rdata completion side for N = 0,1; per_state, per_en,
// per_load, per_store, per_size, per_addr, per_wdata drive the peripheral,
// per_rdata returns its registered read data.
module io_arbiter
    import io_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [2:0]  per_state,
    output logic        per_en,
    output logic        per_load,
    output logic        per_store,
    output logic [1:0]  per_size,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    input  logic [31:0] per_rdata
);

    io_state_t   state_q, state_d;
    logic        take;
    logic        arb_gnt;
    logic        arb_any;

    // Transaction latched at acceptance; inputs are never looked at again
    // until the FSM returns to IDLE.
    logic        gnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;

    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (m0_req),
        .req1 (m1_req),
        .take (take),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    always_comb begin
        sel_we    = arb_gnt ? m1_we    : m0_we;
        sel_size  = arb_gnt ? m1_size  : m0_size;
        sel_addr  = arb_gnt ? m1_addr  : m0_addr;
        sel_wdata = arb_gnt ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    take    = 1'b1;
                    state_d = in_window(sel_addr, IO_BASE) ? ST_ACCESS : ST_ERR;
                end
            end
            ST_ACCESS: state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
        end else begin
            if (take) begin
                gnt_q   <= arb_gnt;
                we_q    <= sel_we;
                size_q  <= sel_size;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            // Peripheral data is valid during WAIT (registered after ACCESS).
            if (state_q == ST_WAIT) begin
                rbuf_q <= per_rdata;
            end
        end
    end

    // All outputs below decode state_q and latched registers only, so no
    // combinational path exists from mN_req.
    logic        done;
    logic [31:0] resp_data;

    always_comb begin
        per_en    = (state_q == ST_ACCESS);
        per_load  = per_en & ~we_q;
        per_store = per_en & we_q;
        per_state = per_en ? PER_ACCESS_STATE : 3'd0;
        per_size  = size_q;
        per_addr  = addr_q;
        per_wdata = wdata_q;

        done      = (state_q == ST_RESP) || (state_q == ST_ERR);
        resp_data = ((state_q == ST_RESP) && !we_q) ? rbuf_q : 32'd0;

        m0_ack    = done & ~gnt_q;
        m1_ack    = done & gnt_q;
        m0_err    = (state_q == ST_ERR) & ~gnt_q;
        m1_err    = (state_q == ST_ERR) & gnt_q;
        m0_rdata  = m0_ack ? resp_data : 32'd0;
        m1_rdata  = m1_ack ? resp_data : 32'd0;
    end

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter with a registered peripheral model.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_arbiter;
    import io_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  per_state;
    logic        per_en, per_load, per_store;
    logic [1:0]  per_size;
    logic [31:0] per_addr, per_wdata;
    logic [31:0] per_rdata = 32'd0;

    always #5 clk = ~clk;

    io_arbiter #(.IO_BASE(32'hFFFF_0000)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .per_state(per_state), .per_en(per_en), .per_load(per_load),
        .per_store(per_store), .per_size(per_size), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_rdata(per_rdata)
    );

    // Peripheral read data as a function of the window offset.
    function automatic logic [31:0] pdata(input logic [31:0] a);
        if (a[3:0] == 4'h4) return 32'h0000_0041;
        return {16'hC0DE, 12'h000, a[3:0]};
    endfunction

    // Peripheral registers its read data one cycle after the access cycle.
    always @(posedge clk) begin
        if (per_en && per_load) per_rdata <= pdata(per_addr);
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   ack_cyc[$];

    // Completion monitor: every ack must match the oldest expected response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (m0_ack || m1_ack) begin
            ack_cyc.push_back(cyc);
            chk("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
                chk("ack_err", {31'd0, e.m ? m1_err : m0_err}, {31'd0, e.err});
                chk("ack_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic expect_rsp(input logic m, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.m = m; e.err = err; e.rdata = rdata;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) step();

        // Reset state
        chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rst_per_en", {31'd0, per_en}, 32'd0);
        chk("rst_per_state", {29'd0, per_state}, 32'd0);
        chk("rst_per_addr", per_addr, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        rst = 1'b0;
        step();

        // m0 word load from the window
        drive(1'b0, 1'b0, SZ_WORD, 32'hFFFF_0004, 32'd0);
        expect_rsp(1'b0, 1'b0, 32'h0000_0041);
        step();
        m0_req = 1'b0;
        chk("ld_per_en", {31'd0, per_en}, 32'd1);
        chk("ld_per_load", {31'd0, per_load}, 32'd1);
        chk("ld_per_store", {31'd0, per_store}, 32'd0);
        chk("ld_per_state", {29'd0, per_state}, 32'd6);
        chk("ld_per_addr", per_addr, 32'hFFFF_0004);
        chk("ld_per_size", {30'd0, per_size}, 32'd2);
        step();
        chk("ld_wait_per_en", {31'd0, per_en}, 32'd0);
        chk("ld_wait_per_state", {29'd0, per_state}, 32'd0);
        step();
        chk("ld_m0_ack_t3", {31'd0, m0_ack}, 32'd1);
        chk("ld_m1_ack_t3", {31'd0, m1_ack}, 32'd0);
        step();
        chk("ld_m0_ack_pulse", {31'd0, m0_ack}, 32'd0);

        // m1 byte store; inputs changed after acceptance must be ignored
        drive(1'b1, 1'b1, SZ_BYTE, 32'hFFFF_0002, 32'd1);
        expect_rsp(1'b1, 1'b0, 32'd0);
        step();
        m1_req = 1'b0; m1_wdata = 32'hDEAD_BEEF; m1_addr = 32'h0000_1000;
        chk("st_per_store", {31'd0, per_store}, 32'd1);
        chk("st_per_load", {31'd0, per_load}, 32'd0);
        chk("st_per_addr", per_addr, 32'hFFFF_0002);
        chk("st_per_wdata", per_wdata, 32'd1);
        chk("st_per_size", {30'd0, per_size}, 32'd0);
        step();
        chk("st_wait_per_store", {31'd0, per_store}, 32'd0);
        chk("st_wait_per_wdata", per_wdata, 32'd1);
        step();
        chk("st_m1_ack_t3", {31'd0, m1_ack}, 32'd1);
        chk("st_resp_per_addr", per_addr, 32'hFFFF_0002);
        step();

        // m0 load outside the window
        drive(1'b0, 1'b0, SZ_WORD, 32'h0000_1000, 32'd0);
        expect_rsp(1'b0, 1'b1, 32'd0);
        step();
        m0_req = 1'b0;
        chk("err_m0_ack_t1", {31'd0, m0_ack}, 32'd1);
        chk("err_per_en", {31'd0, per_en}, 32'd0);
        chk("err_per_state", {29'd0, per_state}, 32'd0);
        step();
        chk("err_m0_ack_pulse", {31'd0, m0_ack}, 32'd0);
        chk("err_idle_per_en", {31'd0, per_en}, 32'd0);

        // Both requesters continuously from reset: m0, m1, m0, m1
        rst = 1'b1;
        drive(1'b0, 1'b0, SZ_WORD, 32'hFFFF_0008, 32'd0);
        drive(1'b1, 1'b0, SZ_WORD, 32'hFFFF_000C, 32'd0);
        expect_rsp(1'b0, 1'b0, pdata(32'hFFFF_0008));
        expect_rsp(1'b1, 1'b0, pdata(32'hFFFF_000C));
        expect_rsp(1'b0, 1'b0, pdata(32'hFFFF_0008));
        expect_rsp(1'b1, 1'b0, pdata(32'hFFFF_000C));
        step();
        rst = 1'b0;
        ack_cyc.delete();
        repeat (13) step();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (6) step();
        chk("rr_ack_count", ack_cyc.size(), 32'd4);
        if (ack_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("rr_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd4);
        end

        // Reset during WAIT drops the transaction and restores m0 priority
        drive(1'b0, 1'b0, SZ_WORD, 32'hFFFF_0004, 32'd0);
        step();
        m0_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rstw_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rstw_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rstw_per_en", {31'd0, per_en}, 32'd0);
        chk("rstw_per_state", {29'd0, per_state}, 32'd0);
        chk("rstw_per_addr", per_addr, 32'd0);
        rst = 1'b0;
        step();
        chk("rstw_idle_ack", {31'd0, m0_ack | m1_ack}, 32'd0);
        drive(1'b0, 1'b0, SZ_WORD, 32'hFFFF_0008, 32'd0);
        drive(1'b1, 1'b0, SZ_WORD, 32'hFFFF_000C, 32'd0);
        expect_rsp(1'b0, 1'b0, pdata(32'hFFFF_0008));
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rstw_grant_m0", per_addr, 32'hFFFF_0008);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("sb_drained", sb.size(), 32'd0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
